// File: rtl/layer_output_serializer_pkg.sv
// Shared definitions for layer_output_serializer: ping-pong slot type,
// slot toggle helper and index-width helper.
package layer_output_serializer_pkg;

  // Default geometry, matching the usual dataWidth / numNeuronLayerN values.
  localparam int DEFAULT_NN = 16;
  localparam int DEFAULT_DW = 16;

  // Which of the two ping-pong entries a pointer refers to.
  typedef enum logic [0:0] {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_e;

  // Width of the word counter / index: clog2(NN), never below one bit.
  function automatic int idx_width(input int nn);
    return (nn > 1) ? $clog2(nn) : 1;
  endfunction

  // The other entry of the ping-pong pair.
  function automatic slot_e other_slot(input slot_e s);
    return (s == SLOT_A) ? SLOT_B : SLOT_A;
  endfunction

endpackage

// File: rtl/layer_output_serializer.sv
// layer_output_serializer
//   Captures a layer's parallel output vector (NN words of DW bits) into a
//   two-entry ping-pong buffer and streams it out one word per valid/ready
//   handshake, lowest neuron first. A vector arriving with no free entry is
//   dropped and flagged on the sticky ovf output.
//   Optional feature macro: SERIALIZER_ARGMAX_EN -- tracks the signed argmax
//   of each streamed frame and reports it on max_idx / max_valid. Without the
//   macro those outputs are tied to zero.
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter  int NN   = DEFAULT_NN,
  parameter  int DW   = DEFAULT_DW,
  localparam int IDXW = idx_width(NN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [NN*DW-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic [IDXW-1:0]    max_idx,
  output logic               max_valid
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

  // Storage: two vector entries, their occupancy flags and the pointers.
  logic [NN*DW-1:0] r_buf [2];
  logic [1:0]       r_full;
  slot_e            r_wr_ptr;
  slot_e            r_rd_ptr;
  logic [IDXW-1:0]  r_cnt;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_drop;
  logic             w_out_valid;
  logic             w_is_last;
  logic             w_hs;
  logic             w_hs_last;
  logic [1:0]       w_full_nxt;
  logic [DW-1:0]    w_words [NN];
  logic [DW-1:0]    w_word;

  // in_ready depends only on registered state, so the upstream layer never
  // sees a combinational path from out_ready.
  assign w_in_ready  = ~r_full[r_wr_ptr];
  assign w_accept    = in_valid & w_in_ready;
  assign w_drop      = in_valid & ~w_in_ready;
  assign w_out_valid = r_full[r_rd_ptr];
  assign w_is_last   = (r_cnt == LAST_IDX);
  assign w_hs        = w_out_valid & out_ready;
  assign w_hs_last   = w_hs & w_is_last;

  // Split the entry being read into words so the counter can select one.
  for (genvar k = 0; k < NN; k++) begin : g_words
    assign w_words[k] = r_buf[r_rd_ptr][k*DW +: DW];
  end
  assign w_word = w_words[r_cnt];

  // Next occupancy: the entry being written is never the entry being freed,
  // because a full write entry blocks the accept.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept) begin
      w_full_nxt[r_wr_ptr] = 1'b1;
    end else begin
      w_full_nxt[r_wr_ptr] = r_full[r_wr_ptr];
    end
    if (w_hs_last) begin
      w_full_nxt[r_rd_ptr] = 1'b0;
    end else begin
      w_full_nxt[r_rd_ptr] = w_full_nxt[r_rd_ptr];
    end
  end

  // Capture the incoming vector into the free entry (data path, no reset).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= in_data;
    end
  end

  // Occupancy flags and write pointer advance on every accepted vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_wr_ptr <= SLOT_A;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_wr_ptr <= other_slot(r_wr_ptr);
      end
    end
  end

  // Read side: word counter steps per handshake, entry released after last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= SLOT_A;
      r_cnt    <= '0;
    end else if (w_hs) begin
      if (w_is_last) begin
        r_cnt    <= '0;
        r_rd_ptr <= other_slot(r_rd_ptr);
      end else begin
        r_cnt <= r_cnt + IDXW'(1);
      end
    end
  end

  // Sticky overflow: a dropped vector wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  // Gate data with valid so an empty buffer presents zero, not stale words.
  assign out_data  = w_out_valid ? w_word : {DW{1'b0}};
  assign out_last  = w_out_valid & w_is_last;
  assign ovf       = r_ovf;

`ifdef SERIALIZER_ARGMAX_EN
  logic signed [DW-1:0] r_run_max;
  logic [IDXW-1:0]      r_run_idx;
  logic [IDXW-1:0]      r_max_idx;
  logic                 r_max_valid;

  logic signed [DW-1:0] w_word_s;
  logic                 w_take;
  logic signed [DW-1:0] w_cand_max;
  logic [IDXW-1:0]      w_cand_idx;

  assign w_word_s = $signed(w_word);

  // Word 0 restarts the running max; later words replace it only when
  // strictly greater, so ties keep the lower index.
  always_comb begin
    w_take = 1'b0;
    if (r_cnt == '0) begin
      w_take = 1'b1;
    end else if (w_word_s > r_run_max) begin
      w_take = 1'b1;
    end else begin
      w_take = 1'b0;
    end
    w_cand_max = w_take ? w_word_s : r_run_max;
    w_cand_idx = w_take ? r_cnt : r_run_idx;
  end

  // Running max per handshake; publish the index after the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_max_idx   <= '0;
      r_max_valid <= 1'b0;
    end else begin
      r_max_valid <= w_hs_last;
      if (w_hs) begin
        r_run_max <= w_cand_max;
        r_run_idx <= w_cand_idx;
      end
      if (w_hs_last) begin
        r_max_idx <= w_cand_idx;
      end
    end
  end

  assign max_idx   = r_max_idx;
  assign max_valid = r_max_valid;
`else
  assign max_idx   = '0;
  assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Scoreboard bench for layer_output_serializer (NN=4, DW=16): directed
// scenarios followed by random traffic, checked against a frame-level model.
module tb_layer_output_serializer;

  localparam int NN   = 4;
  localparam int DW   = 16;
  localparam int IDXW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [NN*DW-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready;
  logic              ovf;
  logic              ovf_clr;
  logic [IDXW-1:0]   max_idx;
  logic              max_valid;

  layer_output_serializer #(.NN(NN), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .max_idx   (max_idx),
    .max_valid (max_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  // Reference model state: expected word stream, frames held, words already sent.
  exp_t          q[$];
  int            occ = 0;
  int            widx = 0;
  logic          exp_ovf = 1'b0;
  logic          pend_mv = 1'b0;
  logic [IDXW-1:0] exp_midx = '0;
  logic [DW-1:0] frame_words[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    frame_words.delete();
    occ = 0;
    widx = 0;
    exp_ovf = 1'b0;
    pend_mv = 1'b0;
    exp_midx = '0;
  endtask

  // Model: at each edge decide accept/drop from frame occupancy and push
  // the accepted frame's words; retire frames as the consumer takes words.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        automatic bit acc = in_valid && (occ < 2);
        if (in_valid && occ >= 2) exp_ovf = 1'b1;
        else if (ovf_clr) exp_ovf = 1'b0;
        if (out_ready && occ > 0) begin
          if (widx == NN - 1) begin
            widx = 0;
            occ--;
          end else begin
            widx++;
          end
        end
        if (acc) begin
          occ++;
          for (int k = 0; k < NN; k++) begin
            exp_t e;
            e.data = in_data[k*DW +: DW];
            e.last = (k == NN - 1);
            q.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: on the falling edge compare the presented word and flags with
  // the scoreboard; pop when the handshake will complete at the next edge.
  initial begin
    forever begin
      automatic logic exp_mv;
      @(negedge clk);
      exp_mv  = pend_mv;
      pend_mv = 1'b0;
      chk("max_valid", max_valid, exp_mv);
      chk("max_idx", max_idx, exp_midx);
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, occ < 2);
      chk("ovf", ovf, exp_ovf);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_last", out_last, q[0].last);
        if (out_ready) begin
          exp_t e;
          e = q.pop_front();
          frame_words.push_back(e.data);
          if (e.last) begin
`ifdef SERIALIZER_ARGMAX_EN
            int best;
            best = 0;
            for (int k = 1; k < NN; k++)
              if ($signed(frame_words[k]) > $signed(frame_words[best])) best = k;
            exp_midx = IDXW'(best);
            pend_mv  = 1'b1;
`endif
            frame_words.delete();
          end
        end
      end else begin
        chk("out_data_idle", out_data, 0);
        chk("out_last_idle", out_last, 0);
      end
    end
  end

  task automatic cyc(input logic iv, input logic [NN*DW-1:0] d, input logic ordy, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, ordy, 1'b0);
  endtask

  // Stimulus: directed scenarios, then random traffic, then drain.
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single vector at full throughput.
    cyc(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Two back-to-back vectors with the consumer stalled, then overflow.
    cyc(1'b1, {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01}, 1'b0, 1'b0);
    cyc(1'b1, {16'h0B04, 16'h0B03, 16'h0B02, 16'h0B01}, 1'b0, 1'b0);
    cyc(1'b1, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD}, 1'b0, 1'b0);
    cyc(1'b1, {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF}, 1'b0, 1'b1);
    idle(3, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Consumer toggling ready.
    cyc(1'b1, {16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01}, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, (i % 2) == 1, 1'b0);

    // Reset in the middle of a frame.
    cyc(1'b1, {16'h0D04, 16'h0D03, 16'h0D02, 16'h0D01}, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, {16'h0E04, 16'h0E03, 16'h0E02, 16'h0E01}, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Signed argmax with a tie: {-3, 7, 7, 2}.
    cyc(1'b1, {16'd2, 16'd7, 16'd7, 16'hFFFD}, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 99) < 35, {$urandom, $urandom}, $urandom_range(0, 99) < 65,
          $urandom_range(0, 99) < 5);
    end

    idle(20, 1'b1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
